// File: rtl/mem_stage_lat.sv
// mem_stage_lat: Y86-64 memory stage with a word-addressed data memory,
// optional access latency with stall handshake, bounds check and W register.
module mem_stage_lat #(
    parameter int DATA_W  = 64,
    parameter int DEPTH   = 1024,
    parameter int MEM_LAT = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [3:0]        M_stat,
    input  logic [3:0]        M_icode,
    input  logic [DATA_W-1:0] M_valE,
    input  logic [DATA_W-1:0] M_valA,
    input  logic [3:0]        M_dstE,
    input  logic [3:0]        M_dstM,
    input  logic              W_stall,
    input  logic              W_bubble,
    output logic [DATA_W-1:0] m_valM,
    output logic [3:0]        m_stat,
    output logic              m_stall,
    output logic [3:0]        W_stat,
    output logic [3:0]        W_icode,
    output logic [DATA_W-1:0] W_valE,
    output logic [DATA_W-1:0] W_valM,
    output logic [3:0]        W_dstE,
    output logic [3:0]        W_dstM
);
    localparam logic [3:0] SAOK    = 4'b1000;
    localparam logic [3:0] SADR    = 4'b0010;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;
    localparam logic [3:0] R_NONE  = 4'hF;

    localparam int                AW       = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [DATA_W-1:0] DEPTH_W  = DATA_W'(DEPTH);
    localparam logic              HAS_LAT  = (MEM_LAT > 0);
    localparam logic [3:0]        CNT_INIT = (MEM_LAT > 0) ? 4'(MEM_LAT - 1) : 4'd0;

    localparam logic S_IDLE = 1'b0;
    localparam logic S_WAIT = 1'b1;

    logic [DATA_W-1:0] r_mem [DEPTH];
    logic              r_state;
    logic [3:0]        r_cnt;

    logic [3:0]        r_w_stat;
    logic [3:0]        r_w_icode;
    logic [DATA_W-1:0] r_w_valE;
    logic [DATA_W-1:0] r_w_valM;
    logic [3:0]        r_w_dstE;
    logic [3:0]        r_w_dstM;

    logic              w_rd;
    logic              w_wr;
    logic              w_use_a;
    logic [DATA_W-1:0] w_addr;
    logic [AW-1:0]     w_idx;
    logic              w_err;
    logic              w_go;
    logic              w_busy;
    logic              w_done;

    // Classify the instruction and choose which operand is the address.
    always_comb begin
        w_rd    = 1'b0;
        w_wr    = 1'b0;
        w_use_a = 1'b0;
        case (M_icode)
            I_MRMOV: w_rd = 1'b1;
            I_RET, I_POP: begin
                w_rd    = 1'b1;
                w_use_a = 1'b1;
            end
            I_RMMOV, I_CALL, I_PUSH: w_wr = 1'b1;
            default: ;
        endcase
    end

    assign w_addr = w_use_a ? M_valA : M_valE;
    assign w_idx  = w_addr[AW-1:0];
    assign w_err  = (w_rd | w_wr) && (w_addr >= DEPTH_W);

    // Only in-range accesses of healthy instructions touch memory or wait.
    assign w_go   = (w_rd | w_wr) && !w_err && (M_stat == SAOK);
    assign w_busy = HAS_LAT && w_go &&
                    ((r_state == S_IDLE) || (r_cnt != 4'd0));
    assign w_done = w_go &&
                    (!HAS_LAT || ((r_state == S_WAIT) && (r_cnt == 4'd0)));

    assign m_stall = w_busy;
    assign m_stat  = w_err ? SADR : M_stat;
    assign m_valM  = (w_rd && w_done) ? r_mem[w_idx] : '0;

    // Latency FSM: count down the wait, frozen while W is stalled.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
        end else if (!W_stall) begin
            if (r_state == S_IDLE) begin
                if (HAS_LAT && w_go) begin
                    r_state <= S_WAIT;
                    r_cnt   <= CNT_INIT;
                end
            end else if (r_cnt == 4'd0) begin
                r_state <= S_IDLE;
            end else begin
                r_cnt <= r_cnt - 4'd1;
            end
        end
    end

    // Store commits only in its completing cycle; reset aborts it.
    always_ff @(posedge clk) begin
        if (rst_n && !W_stall && w_wr && w_done) begin
            r_mem[w_idx] <= M_valA;
        end
    end

    // Writeback register: reset, hold, bubble, or take stage results.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_w_stat  <= SAOK;
            r_w_icode <= I_NOP;
            r_w_valE  <= '0;
            r_w_valM  <= '0;
            r_w_dstE  <= R_NONE;
            r_w_dstM  <= R_NONE;
        end else if (!W_stall) begin
            if (W_bubble || w_busy) begin
                r_w_stat  <= SAOK;
                r_w_icode <= I_NOP;
                r_w_valE  <= '0;
                r_w_valM  <= '0;
                r_w_dstE  <= R_NONE;
                r_w_dstM  <= R_NONE;
            end else begin
                r_w_stat  <= m_stat;
                r_w_icode <= M_icode;
                r_w_valE  <= M_valE;
                r_w_valM  <= m_valM;
                r_w_dstE  <= M_dstE;
                r_w_dstM  <= M_dstM;
            end
        end
    end

    assign W_stat  = r_w_stat;
    assign W_icode = r_w_icode;
    assign W_valE  = r_w_valE;
    assign W_valM  = r_w_valM;
    assign W_dstE  = r_w_dstE;
    assign W_dstM  = r_w_dstM;

endmodule

// File: tb/tb_mem_stage_lat.sv
// tb_mem_stage_lat: scoreboard bench for mem_stage_lat at MEM_LAT 0, 2, 3.
// Driver pushes reference results; a negedge monitor pops and compares.
module tb_mem_stage_lat;
    localparam int NI = 3;
    localparam logic [3:0] SAOK = 4'b1000;

    typedef struct packed {
        logic [3:0]  stat;
        logic [3:0]  icode;
        logic [63:0] valE;
        logic [63:0] valM;
        logic [3:0]  dstE;
        logic [3:0]  dstM;
        int          occ;
        int          nst;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  M_stat, M_icode, M_dstE, M_dstM;
    logic [63:0] M_valE, M_valA;
    logic        W_stall, W_bubble;
    int          act = 0;
    bit          mv = 1'b0;

    logic [63:0] o_valM  [NI];
    logic [3:0]  o_mstat [NI];
    logic        o_stall [NI];
    logic [3:0]  o_wstat [NI];
    logic [3:0]  o_wicode[NI];
    logic [63:0] o_wvalE [NI];
    logic [63:0] o_wvalM [NI];
    logic [3:0]  o_wdstE [NI];
    logic [3:0]  o_wdstM [NI];

    logic [63:0] ref_mem [NI][1024];
    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    for (genvar g = 0; g < NI; g++) begin : g_dut
        logic [3:0] ic;
        logic       ws;
        logic       wb;
        assign ic = (act == g) ? M_icode : 4'h1;
        assign ws = (act == g) && W_stall;
        assign wb = (act == g) && W_bubble;
        mem_stage_lat #(
            .DATA_W (64),
            .DEPTH  (1024),
            .MEM_LAT(g == 0 ? 0 : g + 1)
        ) u_dut (
            .clk     (clk),
            .rst_n   (rst_n),
            .M_stat  (M_stat),
            .M_icode (ic),
            .M_valE  (M_valE),
            .M_valA  (M_valA),
            .M_dstE  (M_dstE),
            .M_dstM  (M_dstM),
            .W_stall (ws),
            .W_bubble(wb),
            .m_valM  (o_valM[g]),
            .m_stat  (o_mstat[g]),
            .m_stall (o_stall[g]),
            .W_stat  (o_wstat[g]),
            .W_icode (o_wicode[g]),
            .W_valE  (o_wvalE[g]),
            .W_valM  (o_wvalM[g]),
            .W_dstE  (o_wdstE[g]),
            .W_dstM  (o_wdstM[g])
        );
    end

    function automatic int lat_of(input int k);
        return (k == 0) ? 0 : k + 1;
    endfunction

    function automatic logic [63:0] rnd64();
        return {$urandom, $urandom};
    endfunction

    function automatic logic [63:0] pick_addr();
        int idx;
        if ($urandom_range(0, 9) < 8) begin
            idx = $urandom_range(0, 19);
            return (idx < 16) ? 64'(idx) : 64'(1004 + idx);
        end
        case ($urandom_range(0, 3))
            0: return 64'd1024;
            1: return 64'd1025;
            2: return 64'h8000_0000_0000_0000;
            default: return '1;
        endcase
    endfunction

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s lat=%0d got=%0h expected=%0h",
                     nm, lat_of(act), got, exp);
        end
    endtask

    // Reference: compute the result and timing from the stage rules.
    task automatic issue(input int k, input logic [3:0] st, ic,
                         input logic [63:0] ve, va,
                         input logic [3:0] de, dm,
                         input int d, n, input bit bub);
        bit          rd, wr, err, ok, ws, done;
        logic [63:0] addr;
        exp_t        e;
        int          need, c, p;
        rd   = (ic == 4'h5) || (ic == 4'h9) || (ic == 4'hB);
        wr   = (ic == 4'h4) || (ic == 4'h8) || (ic == 4'hA);
        addr = ((ic == 4'h9) || (ic == 4'hB)) ? va : ve;
        err  = (rd || wr) && (addr >= 64'd1024);
        ok   = (rd || wr) && !err && (st == SAOK);
        need = ok ? lat_of(k) : 0;
        e.stat  = err ? 4'b0010 : st;
        e.icode = ic;
        e.valE  = ve;
        e.valM  = (rd && ok) ? ref_mem[k][addr[9:0]] : 64'd0;
        e.dstE  = de;
        e.dstM  = dm;
        e.occ   = 0;
        e.nst   = 0;
        c = 0;
        p = 0;
        while (e.occ == 0) begin
            ws = (c >= d) && (c < d + n);
            if (!ws && p == need) begin
                e.occ = c + 1;
            end else begin
                if (p < need) e.nst++;
                if (!ws) p++;
            end
            c++;
        end
        if (wr && ok) ref_mem[k][addr[9:0]] = va;
        if (!bub) exp_q.push_back(e);
        M_stat   = st;
        M_icode  = ic;
        M_valE   = ve;
        M_valA   = va;
        M_dstE   = de;
        M_dstM   = dm;
        W_bubble = bub;
        mv       = 1'b1;
        c    = 0;
        done = 1'b0;
        while (!done && c < 200) begin
            W_stall = (c >= d) && (c < d + n);
            @(negedge clk);
            if (!W_stall && !o_stall[k]) done = 1'b1;
            @(posedge clk);
            #1;
            c++;
        end
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        if (!done) begin
            tests++;
            fails++;
            $display("FAIL timeout lat=%0d icode=%0h", lat_of(k), ic);
        end
    endtask

    bit          p_load = 0, p_bub = 0, p_hold = 0, p_rst = 0;
    logic [63:0] p_mvalM;
    logic [3:0]  p_mstat;
    int          p_occ, p_nst;
    int          occ = 0, nst = 0;
    logic [63:0] h_valE, h_valM;
    logic [15:0] h_misc;
    exp_t        e_m;

    // Monitor: check the W result of the previous edge, then record this one.
    always @(negedge clk) begin
        if (p_rst || p_bub) begin
            chk("bubble_misc", {o_wstat[act], o_wicode[act],
                o_wdstE[act], o_wdstM[act]}, 16'h81FF);
            chk("bubble_valE", o_wvalE[act], 0);
            chk("bubble_valM", o_wvalM[act], 0);
        end
        if (p_hold) begin
            chk("hold_misc", {o_wstat[act], o_wicode[act],
                o_wdstE[act], o_wdstM[act]}, h_misc);
            chk("hold_valE", o_wvalE[act], h_valE);
            chk("hold_valM", o_wvalM[act], h_valM);
        end
        if (p_load) begin
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL scoreboard_empty lat=%0d", lat_of(act));
            end else begin
                e_m = exp_q.pop_front();
                chk("W_stat", o_wstat[act], e_m.stat);
                chk("W_icode", o_wicode[act], e_m.icode);
                chk("W_valE", o_wvalE[act], e_m.valE);
                chk("W_valM", o_wvalM[act], e_m.valM);
                chk("W_dstE", o_wdstE[act], e_m.dstE);
                chk("W_dstM", o_wdstM[act], e_m.dstM);
                chk("m_valM", p_mvalM, e_m.valM);
                chk("m_stat", p_mstat, e_m.stat);
                chk("occupancy", p_occ, e_m.occ);
                chk("stall_cycles", p_nst, e_m.nst);
            end
        end
        p_load = 0;
        p_bub  = 0;
        p_hold = 0;
        p_rst  = 0;
        if (!rst_n) begin
            p_rst = 1;
            occ   = 0;
            nst   = 0;
        end else begin
            if (o_stall[act]) chk("valM_while_stall", o_valM[act], 0);
            if (mv) begin
                occ++;
                if (o_stall[act]) nst++;
            end
            if (W_stall) begin
                p_hold = 1;
                h_misc = {o_wstat[act], o_wicode[act],
                          o_wdstE[act], o_wdstM[act]};
                h_valE = o_wvalE[act];
                h_valM = o_wvalM[act];
            end else begin
                if (mv && !o_stall[act]) begin
                    if (!W_bubble) begin
                        p_load  = 1;
                        p_mvalM = o_valM[act];
                        p_mstat = o_mstat[act];
                        p_occ   = occ;
                        p_nst   = nst;
                    end
                    occ = 0;
                    nst = 0;
                end
                if (W_bubble || o_stall[act]) p_bub = 1;
            end
            if (!mv) begin
                occ = 0;
                nst = 0;
            end
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  ic, st;
        logic [63:0] ve, va, ad;
        int          d, n;
        bit          bub, mem;
        rst_n    = 1'b0;
        M_stat   = SAOK;
        M_icode  = 4'h1;
        M_valE   = '0;
        M_valA   = '0;
        M_dstE   = 4'hF;
        M_dstM   = 4'hF;
        W_stall  = 1'b0;
        W_bubble = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int k = 0; k < NI; k++) begin
            chk("rst_W_stat", o_wstat[k], 4'b1000);
            chk("rst_W_icode", o_wicode[k], 4'h1);
            chk("rst_W_dst", {o_wdstE[k], o_wdstM[k]}, 8'hFF);
            chk("rst_W_vals", o_wvalE[k] | o_wvalM[k], 0);
            chk("rst_m_stall", o_stall[k], 0);
        end
        @(posedge clk);
        #1 rst_n = 1'b1;

        for (int k = 0; k < NI; k++) begin
            mv      = 1'b0;
            M_icode = 4'h1;
            repeat (2) @(posedge clk);
            #1 act = k;
            for (int a = 0; a < 20; a++) begin
                ad = (a < 16) ? 64'(a) : 64'(1004 + a);
                ic = (a % 3 == 0) ? 4'h4 : ((a % 3 == 1) ? 4'h8 : 4'hA);
                issue(k, SAOK, ic, ad, rnd64(), 4'h4, 4'hF, 0, 0, 0);
            end
            issue(k, SAOK, 4'h4, 64'd8, 64'hDEAD, 4'hF, 4'hF, 0, 0, 0);
            issue(k, SAOK, 4'h5, 64'd8, rnd64(), 4'hF, 4'h3, 0, 0, 0);
            issue(k, SAOK, 4'hB, rnd64(), 64'd1024, 4'h4, 4'h3, 0, 0, 0);
            issue(k, SAOK, 4'h5, 64'd8, 64'd0, 4'hF, 4'h2, 0, 0, 0);
            issue(k, SAOK, 4'hA, 64'd100, rnd64(), 4'h4, 4'hF, 0, 0, 0);
            issue(k, SAOK, 4'h5, 64'd100, 64'd0, 4'hF, 4'h1, 0, 0, 0);
            issue(k, 4'b0001, 4'h4, 64'd5, rnd64(), 4'hF, 4'hF, 0, 0, 0);
            issue(k, SAOK, 4'h5, 64'd5, 64'd0, 4'hF, 4'h6, 0, 0, 0);
            issue(k, SAOK, 4'h4, 64'd9, rnd64(), 4'hF, 4'hF, 2, 2, 0);
            issue(k, SAOK, 4'h5, 64'd9, 64'd0, 4'hF, 4'h7, 0, 0, 0);
            issue(k, SAOK, 4'h6, rnd64(), rnd64(), 4'h2, 4'hF, 0, 0, 1);
            if (lat_of(k) > 0) begin
                mv      = 1'b0;
                M_stat  = SAOK;
                M_icode = 4'h4;
                M_valE  = 64'd7;
                M_valA  = 64'h1234_5678_9ABC_DEF0;
                @(posedge clk);
                #1 rst_n = 1'b0;
                @(posedge clk);
                #1 rst_n = 1'b1;
                M_icode = 4'h1;
                @(posedge clk);
                #1;
            end
            issue(k, SAOK, 4'h5, 64'd7, 64'd0, 4'hF, 4'h8, 0, 0, 0);
            for (int i = 0; i < 60; i++) begin
                ic  = 4'($urandom_range(0, 15));
                st  = SAOK;
                if ($urandom_range(0, 9) >= 8) begin
                    case ($urandom_range(0, 2))
                        0: st = 4'b0100;
                        1: st = 4'b0010;
                        default: st = 4'b0001;
                    endcase
                end
                ve  = rnd64();
                va  = rnd64();
                mem = (ic == 4'h4) || (ic == 4'h5) || (ic == 4'h8) ||
                      (ic == 4'h9) || (ic == 4'hA) || (ic == 4'hB);
                if (mem) begin
                    ad = pick_addr();
                    if (ic == 4'h9 || ic == 4'hB) va = ad;
                    else ve = ad;
                end
                d = 0;
                n = 0;
                if ($urandom_range(0, 3) == 0) begin
                    d = $urandom_range(0, 3);
                    n = $urandom_range(1, 2);
                end
                bub = !mem && ($urandom_range(0, 7) == 0);
                issue(k, st, ic, ve, va, 4'($urandom_range(0, 15)),
                      4'($urandom_range(0, 15)), d, n, bub);
            end
        end
        mv      = 1'b0;
        M_icode = 4'h1;
        repeat (3) @(posedge clk);
        #1;
        chk("queue_empty", exp_q.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mem_stage_lat.md
# mem_stage_lat

Parametrised Y86-64 pipeline memory stage. It sits between the execute/memory pipeline register (M) and writeback (W). It owns a word-addressed data memory of configurable width and depth and performs the loads, stores and stack accesses of the memory stage. It adds configurable access latency with a stall handshake to the hazard unit, non-sticky per-instruction bounds errors, and store suppression for faulted instructions.

## Interface
- DATA_W, 64, data word and valE/valA width
- DEPTH, 1024, memory words; valid addresses 0..DEPTH-1
- MEM_LAT, 0, extra cycles per load/store (0..15)
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  reset, synchronous and active-low
- M_stat  in  4  status from M (SAOK 1000, SHLT 0100, SADR 0010, SINS 0001)
- M_icode  in  4  instruction code
- M_valE, M_valA  in  DATA_W  ALU result / operand A
- M_dstE, M_dstM  in  4  destination registers (F = none)
- W_stall  in  1  hold W register and this block's state
- W_bubble  in  1  load bubble into W
- m_valM  out  DATA_W  combinational read data
- m_stat  out  4  combinational stage status
- m_stall  out  1  access in progress; hazard unit must hold M and stall upstream
- W_stat, W_icode, W_valE, W_valM, W_dstE, W_dstM  out  4/4/DATA_W/DATA_W/4/4  writeback register

## Operation
- Reads: icode 5 (mrmovq) at valE; icode 9 (ret) and B (popq) at valA.
- Writes of valA: icode 4 (rmmovq), 8 (call), A (pushq) at valE.
- Any other icode is a non-memory op: m_valM = 0, no wait.
- Address error: the relevant address, compared on all DATA_W bits, is ≥ DEPTH. Then m_stat = SADR, m_valM = 0, no write, no wait.
- Otherwise m_stat = M_stat.
- Errors are evaluated per instruction and are never sticky.
- A store is suppressed when M_stat ≠ SAOK. A faulted instruction never wait-cycles.
- FSM states: IDLE and WAIT; counter cnt is 4 bits.
  - IDLE, valid mem op, MEM_LAT>0: m_stall=1, cnt<=MEM_LAT-1, go to WAIT.
  - WAIT with cnt≠0: m_stall=1, cnt decrements.
  - WAIT with cnt=0: m_stall=0, access completes, go to IDLE.
  - MEM_LAT=0: the FSM stays in IDLE and m_stall is always 0.
- A store commits at the rising edge of its completing cycle: the IDLE cycle when MEM_LAT=0, else the WAIT cycle with cnt=0.
- m_valM is valid only in the completing cycle; it is 0 while m_stall=1.
- W update priority: reset > W_stall (hold all, including FSM, cnt and store) > W_bubble or m_stall (load bubble) > load stage results.
- Bubble value: stat SAOK, icode 1, valE 0, valM 0, dstE F, dstM F.
- Memory contents are not reset.

## Timing
- Reset (rst_n=0 at an edge) leaves: W at the bubble value, FSM in IDLE, cnt 0, m_stall 0.
- Reset during WAIT aborts the access with no write.
- Latency M→W is 1 cycle at MEM_LAT=0, and MEM_LAT+1 cycles otherwise. M occupancy equals the same count.
- Back-to-back accesses: the next op is accepted in IDLE the cycle after completion. Throughput is one access per MEM_LAT+1 cycles.
- Store followed by a load to the same address returns the new data, because the store commits at the edge before the load is evaluated.
- m_stall is combinational from FSM state, M_icode, M_stat and the address check. It has no dependence on W_stall.
- W_stall held during WAIT freezes cnt. The wait resumes unchanged when W_stall drops.

## Test plan
- Reset: rst_n=0 for 2 edges → W_icode=1, W_dstE=W_dstM=F, W_stat=1000, m_stall=0.
- MEM_LAT=0: rmmovq valE=8, valA=0xDEAD; next cycle mrmovq valE=8 → m_valM=0xDEAD, W_valM=0xDEAD one edge later.
- Bounds, DEPTH=1024: popq valA=1024 → m_stat=0010, m_valM=0, no write, W_stat=0010. The next valid instruction gets m_stat=M_stat.
- MEM_LAT=3: pushq valE=100 → m_stall high exactly 3 cycles, W gets 3 bubbles, mem[100] written at the 4th edge.
- Faulted store: rmmovq with M_stat=0001, valE=5 → mem[5] unchanged, W_stat=0001, no stall.
- W_stall mid-WAIT, MEM_LAT=2: assert 2 cycles after the first stall cycle → cnt frozen and W held; completion is delayed exactly 2 cycles.
